// File: rtl/bus_arb_pkg.sv
// Shared host-ID type and the arbitration helper used by bus_host_arbiter.
// Host IDs are sized for the largest supported host count, so one package serves every NrHosts.
package bus_arb_pkg;

  localparam int unsigned MaxHosts    = 8;
  localparam int unsigned HostIdWidth = $clog2(MaxHosts);

  typedef logic [HostIdWidth-1:0] host_id_t;
  typedef logic [MaxHosts-1:0]    host_vec_t;

  // Scan upward from start with 3-bit wrap; unused request bits are zero and get skipped.
  function automatic host_id_t rr_pick(input host_vec_t req, input host_id_t start);
    host_id_t idx;
    host_id_t pick;
    logic     found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < int'(MaxHosts); i++) begin
      idx = start + host_id_t'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs, one entry per outstanding transaction.
// Pointers carry one wrap bit beyond the index so full and empty are distinguishable.
module bus_arb_id_fifo import bus_arb_pkg::*; #(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_sys_i,
  input  logic     rst_sys_ni,
  input  logic     push_i,
  input  host_id_t push_id_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output host_id_t head_o
);

  localparam int unsigned     PtrW    = $clog2(2 * Depth);
  localparam logic [PtrW-1:0] IdxMask = PtrW'(Depth - 1);
  localparam logic [PtrW-1:0] FullXor = PtrW'(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  host_id_t        mem_q [Depth];
  host_id_t        mem_d [Depth];
  logic            push_ok_s;
  logic            pop_ok_s;

  // Pointer arithmetic, storage write and head read.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = ((wr_ptr_q ^ rd_ptr_q) == FullXor);
    push_ok_s = push_i & ~full_o;
    pop_ok_s  = pop_i & ~empty_o;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
    head_o    = host_id_t'(0);
    for (int i = 0; i < int'(Depth); i++) begin
      mem_d[i] = (push_ok_s && ((wr_ptr_q & IdxMask) == PtrW'(i))) ? push_id_i : mem_q[i];
      head_o   = ((rd_ptr_q & IdxMask) == PtrW'(i)) ? mem_q[i] : head_o;
    end
  end

  // State registers; reset flushes the FIFO.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= host_id_t'(0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Arbitrates NrHosts OBI-style hosts onto one device request channel and routes responses back in order.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest requesting index wins.
module bus_host_arbiter import bus_arb_pkg::*; #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_ni,
  input  logic [NrHosts-1:0]      host_req_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]      host_err_o,
  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic [AddressWidth-1:0] dev_addr_o,
  output logic                    dev_we_o,
  output logic [DataWidth/8-1:0]  dev_be_o,
  output logic [DataWidth-1:0]    dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [DataWidth-1:0]    dev_rdata_i,
  input  logic                    dev_err_i,
  output logic                    busy_o,
  output logic                    spurious_rsp_o
);

  logic     lock_q, lock_d;
  host_id_t lock_id_q, lock_id_d;
  logic     spurious_q, spurious_d;
  host_id_t start_s, sel_s, head_s;
  logic     fifo_full_s, fifo_empty_s;
  logic     handshake_s, pop_s;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  host_id_t last_grant_q, last_grant_d;
`endif

  // Priority start point: one past the last winner, or host 0 under fixed priority.
  always_comb begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
    if (last_grant_q == host_id_t'(NrHosts - 1)) begin
      start_s = host_id_t'(0);
    end else begin
      start_s = last_grant_q + host_id_t'(1);
    end
    last_grant_d = handshake_s ? sel_s : last_grant_q;
`else
    start_s = host_id_t'(0);
`endif
  end

  // Request path: selection, device-side mux, grant and lock update.
  always_comb begin
    sel_s       = lock_q ? lock_id_q : rr_pick(host_vec_t'(host_req_i), start_s);
    dev_req_o   = (|host_req_i) & ~fifo_full_s;
    handshake_s = dev_req_o & dev_gnt_i;
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    host_gnt_o  = '0;
    for (int i = 0; i < int'(NrHosts); i++) begin
      dev_addr_o    = (sel_s == host_id_t'(i)) ? host_addr_i[i]  : dev_addr_o;
      dev_we_o      = (sel_s == host_id_t'(i)) ? host_we_i[i]    : dev_we_o;
      dev_be_o      = (sel_s == host_id_t'(i)) ? host_be_i[i]    : dev_be_o;
      dev_wdata_o   = (sel_s == host_id_t'(i)) ? host_wdata_i[i] : dev_wdata_o;
      host_gnt_o[i] = handshake_s & (sel_s == host_id_t'(i));
    end
    // An ungranted request pins its host so the OBI request stays stable.
    if (handshake_s) begin
      lock_d    = 1'b0;
      lock_id_d = lock_id_q;
    end else if (dev_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel_s;
    end else begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
    end
  end

  // Response path: route to the FIFO head, flag responses nobody is waiting for.
  always_comb begin
    pop_s      = dev_rvalid_i & ~fifo_empty_s;
    spurious_d = spurious_q | (dev_rvalid_i & fifo_empty_s);
    for (int i = 0; i < int'(NrHosts); i++) begin
      host_rvalid_o[i] = pop_s & (head_s == host_id_t'(i));
      host_err_o[i]    = pop_s & dev_err_i & (head_s == host_id_t'(i));
      host_rdata_o[i]  = dev_rdata_i;
    end
  end

  assign busy_o         = ~fifo_empty_s;
  assign spurious_rsp_o = spurious_q;

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .push_i     (handshake_s),
    .push_id_i  (sel_s),
    .pop_i      (pop_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .head_o     (head_s)
  );

  // Arbiter state registers.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      lock_q       <= 1'b0;
      lock_id_q    <= host_id_t'(0);
      spurious_q   <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_grant_q <= host_id_t'(NrHosts - 1);
`endif
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      spurious_q   <= spurious_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
